// File: rtl/scrambler_lanes_if.sv
// Beat-level handshake between a 128b/130b framer and the lane scrambler.
// The master drives the input beat; the slave returns the registered output beat.
interface scrambler_lanes_if #(
    parameter int LANES      = 4,
    parameter int DATA_BYTES = 4
);
    localparam int DW = LANES * DATA_BYTES * 8;

    logic          in_valid;
    logic          in_block_start;
    logic [1:0]    in_sync_hdr;
    logic [DW-1:0] in_data;

    logic          out_valid;
    logic          out_block_start;
    logic [1:0]    out_sync_hdr;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, in_block_start, in_sync_hdr, in_data,
        input  out_valid, out_block_start, out_sync_hdr, out_data
    );

    modport slave (
        input  in_valid, in_block_start, in_sync_hdr, in_data,
        output out_valid, out_block_start, out_sync_hdr, out_data
    );
endinterface

// File: rtl/scrambler_lanes.sv
// Multi-lane 128b/130b scrambler with block framing checks.
// Each lane runs a Galois LFSR (x^23+x^21+x^16+x^8+x^5+x^2+1); all bit steps
// of one beat are unrolled, and every output is registered (1-cycle latency).
//
// blk_type | meaning
// BLK_OS   | current block is an ordered set: data passes through unscrambled
// BLK_DATA | current block is a data block: data is scrambled
module scrambler_lanes #(
    parameter int LANES      = 4,
    parameter int DATA_BYTES = 4
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    input  logic                 turnOff,
    input  logic                 seed_load,
    input  logic [LANES*23-1:0]  lane_seed,
    scrambler_lanes_if.slave     bus,
    output logic                 block_err
);
    localparam int          LANE_W    = DATA_BYTES * 8;
    localparam int          DW        = LANES * LANE_W;
    localparam int          BEATS     = 16 / DATA_BYTES;
    localparam logic [3:0]  LAST_BEAT = 4'(BEATS - 1);
    localparam logic [22:0] POLY      = 23'h210125;
    localparam logic [22:0] LFSR_RST  = 23'h7FFFFF;

    typedef enum logic {
        BLK_OS   = 1'b0,
        BLK_DATA = 1'b1
    } blk_type_e;

    logic [LANES-1:0][22:0] lfsr_q, lfsr_d, lfsr_step;
    logic [3:0]             cnt_q, cnt_d;
    blk_type_e              blk_type_q, blk_type_d;
    logic                   skp_q, skp_d;
    logic                   eieos_q, eieos_d;

    logic                   out_valid_q, out_valid_d;
    logic                   out_bs_q, out_bs_d;
    logic [1:0]             out_hdr_q, out_hdr_d;
    logic [DW-1:0]          out_data_q, out_data_d;
    logic                   block_err_q, block_err_d;

    logic [DW-1:0]          scr_data;
    logic                   framed;
    logic                   beat_data;
    logic                   beat_skp;
    logic                   beat_eieos;
    logic                   beat_last;

    // Unrolled per-lane keystream: scramble every bit of the beat and produce the advanced LFSR.
    always_comb begin
        logic [22:0] lv;
        scr_data  = '0;
        lfsr_step = lfsr_q;
        lv        = '0;
        for (int ln = 0; ln < LANES; ln++) begin
            lv = lfsr_q[ln];
            for (int b = 0; b < LANE_W; b++) begin
                scr_data[ln*LANE_W+b] = bus.in_data[ln*LANE_W+b] ^ lv[22];
                lv = {lv[21:0], 1'b0} ^ (lv[22] ? POLY : 23'h0);
            end
            lfsr_step[ln] = lv;
        end
    end

    // Block framing: beat counter, latched block type/flags and framing errors.
    // An unframed beat (no block start while idle) is flagged and treated as outside any block.
    always_comb begin
        cnt_d       = cnt_q;
        blk_type_d  = blk_type_q;
        skp_d       = skp_q;
        eieos_d     = eieos_q;
        block_err_d = 1'b0;
        framed      = 1'b0;
        beat_last   = 1'b0;
        beat_data   = 1'b0;
        beat_skp    = 1'b0;
        beat_eieos  = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_block_start) begin
                framed      = 1'b1;
                block_err_d = (cnt_q != 4'd0) ||
                              !((bus.in_sync_hdr == 2'b10) || (bus.in_sync_hdr == 2'b01));
                blk_type_d  = (bus.in_sync_hdr == 2'b10) ? BLK_DATA : BLK_OS;
                skp_d       = (bus.in_sync_hdr != 2'b10) && (bus.in_data[7:0] == 8'hAA);
                eieos_d     = (bus.in_sync_hdr != 2'b10) && (bus.in_data[7:0] == 8'h00);
                beat_last   = (LAST_BEAT == 4'd0);
                cnt_d       = beat_last ? 4'd0 : 4'd1;
            end else if (cnt_q == 4'd0) begin
                block_err_d = 1'b1;
            end else begin
                framed    = 1'b1;
                beat_last = (cnt_q == LAST_BEAT);
                cnt_d     = beat_last ? 4'd0 : cnt_q + 4'd1;
            end
            beat_data  = framed && (blk_type_d == BLK_DATA);
            beat_skp   = framed && skp_d;
            beat_eieos = framed && eieos_d;
        end
    end

    // LFSR update: seed load beats EIEOS reload beats bypass/SKP hold beats advance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = lane_seed;
        end else if (beat_eieos && beat_last) begin
            lfsr_d = lane_seed;
        end else if (framed && !turnOff && !beat_skp) begin
            lfsr_d = lfsr_step;
        end
    end

    // Output stage inputs; out_data only changes on valid beats.
    always_comb begin
        out_valid_d = bus.in_valid;
        out_bs_d    = bus.in_block_start;
        out_hdr_d   = bus.in_sync_hdr;
        out_data_d  = out_data_q;
        if (bus.in_valid) begin
            out_data_d = (beat_data && !turnOff) ? scr_data : bus.in_data;
        end
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q      <= {LANES{LFSR_RST}};
            cnt_q       <= 4'd0;
            blk_type_q  <= BLK_OS;
            skp_q       <= 1'b0;
            eieos_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_bs_q    <= 1'b0;
            out_hdr_q   <= 2'b00;
            out_data_q  <= '0;
            block_err_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            blk_type_q  <= blk_type_d;
            skp_q       <= skp_d;
            eieos_q     <= eieos_d;
            out_valid_q <= out_valid_d;
            out_bs_q    <= out_bs_d;
            out_hdr_q   <= out_hdr_d;
            out_data_q  <= out_data_d;
            block_err_q <= block_err_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_block_start = out_bs_q;
    assign bus.out_sync_hdr    = out_hdr_q;
    assign bus.out_data        = out_data_q;
    assign block_err           = block_err_q;
endmodule

// File: tb/tb_scrambler_lanes.sv
// Scoreboard bench for scrambler_lanes: a bit-serial block-level model predicts each
// cycle's output; a monitor one cycle later compares what the DUT presents.
module tb_scrambler_lanes;
    localparam int LANES = 4;
    localparam int DB    = 4;
    localparam int LW    = DB * 8;
    localparam int DW    = LANES * LW;
    localparam int BEATS = 16 / DB;

    typedef struct {
        logic          v;
        logic          bs;
        logic [1:0]    hdr;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    typedef logic [DW-1:0] blk_t [BEATS];

    logic                pclk = 1'b0;
    logic                reset_n = 1'b0;
    logic                turnOff = 1'b0;
    logic                seed_load = 1'b0;
    logic [LANES*23-1:0] lane_seed = '0;
    logic                block_err;

    scrambler_lanes_if #(.LANES(LANES), .DATA_BYTES(DB)) bus ();

    scrambler_lanes #(.LANES(LANES), .DATA_BYTES(DB)) dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .turnOff   (turnOff),
        .seed_load (seed_load),
        .lane_seed (lane_seed),
        .bus       (bus),
        .block_err (block_err)
    );

    always #5 pclk = ~pclk;

    int            checks = 0;
    int            failures = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] cap_q[$];
    exp_t          mon_e;

    // reference model state: symbols consumed in the current block (0 = expecting a block start)
    logic [22:0]   m_lfsr [LANES];
    int            m_sym;
    bit            m_is_data, m_skp, m_eieos;
    logic [DW-1:0] m_last;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [22:0] galois_step(input logic [22:0] s);
        logic [22:0] n;
        n    = s << 1;
        n[0] = s[22];
        if (s[22]) begin
            n[2]  = ~n[2];
            n[5]  = ~n[5];
            n[8]  = ~n[8];
            n[16] = ~n[16];
            n[21] = ~n[21];
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int ln = 0; ln < LANES; ln++) m_lfsr[ln] = 23'h7FFFFF;
        m_sym     = 0;
        m_is_data = 1'b0;
        m_skp     = 1'b0;
        m_eieos   = 1'b0;
        m_last    = '0;
    endtask

    task automatic model_cycle(input logic v, input logic bs, input logic [1:0] hdr,
                               input logic [DW-1:0] d, input logic toff, input logic sl);
        exp_t        e;
        bit          in_blk, blk_end, scr;
        logic [22:0] adv [LANES];
        logic [7:0]  byt;
        e.v = v; e.bs = bs; e.hdr = hdr; e.err = 1'b0; e.data = m_last;
        in_blk  = 1'b0;
        blk_end = 1'b0;
        for (int ln = 0; ln < LANES; ln++) adv[ln] = m_lfsr[ln];
        if (v) begin
            if (bs) begin
                e.err     = (m_sym != 0) || !((hdr == 2'b10) || (hdr == 2'b01));
                m_sym     = 0;
                m_is_data = (hdr == 2'b10);
                m_skp     = !m_is_data && (d[7:0] == 8'hAA);
                m_eieos   = !m_is_data && (d[7:0] == 8'h00);
                in_blk    = 1'b1;
            end else if (m_sym == 0) begin
                e.err = 1'b1;
            end else begin
                in_blk = 1'b1;
            end
            scr    = in_blk && m_is_data && !toff;
            e.data = d;
            for (int ln = 0; ln < LANES; ln++) begin
                for (int k = 0; k < DB; k++) begin
                    byt = d[ln*LW + k*8 +: 8];
                    for (int j = 0; j < 8; j++) begin
                        if (scr) e.data[ln*LW + k*8 + j] = byt[j] ^ adv[ln][22];
                        adv[ln] = galois_step(adv[ln]);
                    end
                end
            end
            if (in_blk) begin
                m_sym += DB;
                if (m_sym == 16) begin
                    blk_end = 1'b1;
                    m_sym   = 0;
                end
            end
            m_last = e.data;
        end
        exp_q.push_back(e);
        if (sl || (blk_end && m_eieos)) begin
            for (int ln = 0; ln < LANES; ln++) m_lfsr[ln] = lane_seed[ln*23 +: 23];
        end else if (in_blk && !toff && !m_skp) begin
            for (int ln = 0; ln < LANES; ln++) m_lfsr[ln] = adv[ln];
        end
    endtask

    task automatic drive(input logic v, input logic bs, input logic [1:0] hdr,
                         input logic [DW-1:0] d, input logic toff, input logic sl);
        @(negedge pclk);
        bus.in_valid       = v;
        bus.in_block_start = bs;
        bus.in_sync_hdr    = hdr;
        bus.in_data        = d;
        turnOff            = toff;
        seed_load          = sl;
        model_cycle(v, bs, hdr, d, toff, sl);
    endtask

    task automatic rand_data(output logic [DW-1:0] d);
        for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
    endtask

    task automatic make_blk(output blk_t b, input int b0);
        for (int i = 0; i < BEATS; i++) rand_data(b[i]);
        if (b0 >= 0) b[0][7:0] = 8'(b0);
    endtask

    task automatic send(input logic [1:0] hdr, input blk_t b, input logic toff);
        for (int i = 0; i < BEATS; i++) drive(1'b1, (i == 0), hdr, b[i], toff, 1'b0);
    endtask

    task automatic load_seed();
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        @(posedge pclk);
        #2;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", DW'(bus.out_valid), '0);
        chk("rst_out_bs", DW'(bus.out_block_start), '0);
        chk("rst_out_hdr", DW'(bus.out_sync_hdr), '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_block_err", DW'(block_err), '0);
    endtask

    // Monitor: one expectation per driven cycle, compared one cycle after it was driven.
    always @(posedge pclk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("out_valid", DW'(bus.out_valid), DW'(mon_e.v));
            chk("out_data", bus.out_data, mon_e.data);
            chk("block_err", DW'(block_err), DW'(mon_e.err));
            if (mon_e.v) begin
                chk("out_block_start", DW'(bus.out_block_start), DW'(mon_e.bs));
                chk("out_sync_hdr", DW'(bus.out_sync_hdr), DW'(mon_e.hdr));
            end
        end else begin
            chk("idle_out_valid", DW'(bus.out_valid), '0);
        end
        if (bus.out_valid) cap_q.push_back(bus.out_data);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t          a, b, s, e, z, r;
        logic [DW-1:0] d;
        int            kind;
        logic [1:0]    hdr;
        bus.in_valid       = 1'b0;
        bus.in_block_start = 1'b0;
        bus.in_sync_hdr    = 2'b00;
        bus.in_data        = '0;
        model_reset();
        for (int i = 0; i < BEATS; i++) z[i] = '0;

        // power-on reset
        repeat (2) @(negedge pclk);
        chk_reset_outputs();
        reset_n = 1'b1;

        // all-zero seeds with zero data give zero output
        lane_seed = '0;
        load_seed();
        send(2'b10, z, 1'b0);
        drain();

        // distinct lane seeds on zero data: keystream per lane, lanes differ
        lane_seed = {23'h18C0DB, 23'h1EC760, 23'h0607BB, 23'h1DBFBC};
        cap_q.delete();
        load_seed();
        send(2'b10, z, 1'b0);
        drain();
        checks++;
        if (cap_q.size() == 0 || cap_q[0][31:0] === cap_q[0][63:32]) begin
            failures++;
            $display("FAIL lanes_differ lane0=%0h lane1=%0h", cap_q[0][31:0], cap_q[0][63:32]);
        end

        // SKP block leaves the keystream untouched for the next data block
        make_blk(a, -1);
        make_blk(b, -1);
        make_blk(s, 8'hAA);
        cap_q.delete();
        load_seed();
        send(2'b10, a, 1'b0);
        send(2'b10, b, 1'b0);
        drain();
        for (int i = 0; i < BEATS; i++) r[i] = cap_q[BEATS+i];
        cap_q.delete();
        load_seed();
        send(2'b10, a, 1'b0);
        send(2'b01, s, 1'b0);
        send(2'b10, b, 1'b0);
        drain();
        chk("skp_cap_count", DW'(cap_q.size()), DW'(3*BEATS));
        if (cap_q.size() == 3*BEATS)
            for (int i = 0; i < BEATS; i++) chk("skp_removed", cap_q[2*BEATS+i], r[i]);

        // EIEOS reloads the seeds after its last beat
        make_blk(e, 8'h00);
        cap_q.delete();
        load_seed();
        send(2'b10, a, 1'b0);
        drain();
        for (int i = 0; i < BEATS; i++) r[i] = cap_q[i];
        cap_q.delete();
        send(2'b01, e, 1'b0);
        send(2'b10, a, 1'b0);
        drain();
        chk("eieos_cap_count", DW'(cap_q.size()), DW'(2*BEATS));
        if (cap_q.size() == 2*BEATS)
            for (int i = 0; i < BEATS; i++) chk("eieos_reload", cap_q[BEATS+i], r[i]);

        // block start at beat 2 restarts the block, following block is clean
        drive(1'b1, 1'b1, 2'b10, a[0], 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b10, a[1], 1'b0, 1'b0);
        for (int i = 0; i < BEATS; i++) drive(1'b1, (i == 0), 2'b10, b[i], 1'b0, 1'b0);
        send(2'b10, a, 1'b0);
        drain();

        // bypass during a data block, then resume from the held state; mid-block toggle too
        send(2'b10, a, 1'b1);
        send(2'b10, b, 1'b0);
        for (int i = 0; i < BEATS; i++) drive(1'b1, (i == 0), 2'b10, a[i], logic'(i[0]), 1'b0);
        drain();

        // illegal headers are errors and behave as ordered sets
        send(2'b11, a, 1'b0);
        send(2'b00, s, 1'b0);
        send(2'b10, b, 1'b0);
        // unframed beat while idle
        drive(1'b1, 1'b0, 2'b10, a[1], 1'b0, 1'b0);
        send(2'b10, b, 1'b0);
        // seed_load wins over advance on a valid beat, and over an EIEOS last-beat reload
        drive(1'b1, 1'b1, 2'b10, a[0], 1'b0, 1'b1);
        for (int i = 1; i < BEATS; i++) drive(1'b1, 1'b0, 2'b10, a[i], 1'b0, 1'b0);
        for (int i = 0; i < BEATS; i++)
            drive(1'b1, (i == 0), 2'b01, e[i], 1'b1, (i == BEATS-1));
        send(2'b10, b, 1'b0);
        drain();

        // reset mid-block discards the block; first beat afterwards needs a block start
        drive(1'b1, 1'b1, 2'b10, a[0], 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b10, a[1], 1'b0, 1'b0);
        drain();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge pclk);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 2'b10, a[2], 1'b0, 1'b0);
        send(2'b10, b, 1'b0);
        drain();

        // randomized traffic with gaps, bypass, reseeds and mixed block types
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(9);
            hdr  = (kind < 5) ? 2'b10 : 2'b01;
            if ($urandom_range(14) == 0) begin
                lane_seed = (LANES*23)'({$urandom(), $urandom(), $urandom()});
                load_seed();
            end
            for (int i = 0; i < BEATS; i++) begin
                while ($urandom_range(3) == 0) begin
                    rand_data(d);
                    drive(1'b0, 1'b0, 2'b00, d, logic'($urandom_range(1)), 1'b0);
                end
                rand_data(d);
                if (i == 0) begin
                    if (kind == 5 || kind == 6) d[7:0] = 8'hAA;
                    else if (kind == 7) d[7:0] = 8'h00;
                    else if (kind > 7 && (d[7:0] == 8'hAA || d[7:0] == 8'h00)) d[7:0] = 8'h1C;
                end
                drive(1'b1, (i == 0), hdr, d, ($urandom_range(9) == 0), 1'b0);
            end
        end
        drain();
        chk("scoreboard_empty", DW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scrambler_lanes.md
SCRAMBLER_LANES -- requirements
Module: scrambler_lanes

Interface
REQ-001 The module SHALL have parameter LANES, default 4, meaning the number of independent lanes (1..16).
REQ-002 The module SHALL have parameter DATA_BYTES, default 4, meaning the bytes per lane per beat (1, 2 or 4).
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset; port pclk is the clock and port reset_n is the reset.
REQ-004 Port pclk SHALL be an input, 1 bit wide: rising-edge clock.
REQ-005 Port reset_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-006 Port turnOff SHALL be an input, 1 bit wide: scrambling bypass; data passes unmodified and LFSRs hold.
REQ-007 Port seed_load SHALL be an input, 1 bit wide: one-cycle pulse that loads lane_seed into every LFSR.
REQ-008 Port lane_seed SHALL be an input, LANES*23 bits wide: per-lane 23-bit seed, with lane n at [23n+22:23n].
REQ-009 Port in_valid SHALL be an input, 1 bit wide: the input beat is valid.
REQ-010 Port in_block_start SHALL be an input, 1 bit wide: the beat carries symbol 0 of a 128b/130b block.
REQ-011 Port in_sync_hdr SHALL be an input, 2 bits wide: the sync header, sampled with in_block_start; 2'b10 means data, 2'b01 means ordered set.
REQ-012 Port in_data SHALL be an input, LANES*DATA_BYTES*8 bits wide: lane data, with byte 0 transmitted first.
REQ-013 Port out_valid SHALL be an output, 1 bit wide: the output beat is valid.
REQ-014 Port out_block_start SHALL be an output, 1 bit wide: the delayed in_block_start.
REQ-015 Port out_sync_hdr SHALL be an output, 2 bits wide: the delayed in_sync_hdr.
REQ-016 Port out_data SHALL be an output, LANES*DATA_BYTES*8 bits wide: scrambled data.
REQ-017 Port block_err SHALL be an output, 1 bit wide: one-cycle pulse on block framing violation.

Function
REQ-018 The scrambler SHALL use, per lane, the Galois LFSR for x^23+x^21+x^16+x^8+x^5+x^2+1, stepping once per data bit, LSB of each byte first.
REQ-019 Each scrambled bit SHALL equal the data bit XOR lfsr[22] before that step; all DATA_BYTES*8 steps per beat SHALL be unrolled combinationally.
REQ-020 A block SHALL be 16 symbols, i.e. 16/DATA_BYTES beats, tracked by a shared beat counter that advances only on in_valid and wraps to 0 after the last beat.
REQ-021 The block type SHALL be latched from in_sync_hdr at in_block_start and SHALL hold for the whole block.
REQ-022 Data-block beats SHALL be scrambled, and the LFSRs SHALL advance.
REQ-023 Ordered-set beats SHALL pass unscrambled, and the LFSRs SHALL advance.
REQ-024 An exception to REQ-023: if lane 0 symbol 0 of the ordered set equals 8'hAA (SKP), all LFSRs SHALL hold for that entire block.
REQ-025 If lane 0 symbol 0 of an ordered set equals 8'h00 (EIEOS), all LFSRs SHALL reload lane_seed on the beat after the block's last beat.
REQ-026 While in_valid=0, the LFSRs, the counter and the latched type SHALL hold.
REQ-027 When turnOff=1, out_data SHALL equal in_data, and the LFSRs SHALL hold; the counter SHALL still track.
REQ-028 seed_load SHALL take priority over advance, EIEOS reload and turnOff in the same cycle.
REQ-029 in_block_start arriving while the counter is nonzero SHALL pulse block_err for one cycle and restart the block at beat 0 using the new header.
REQ-030 An in_block_start with sync header 2'b00 or 2'b11 SHALL pulse block_err and SHALL be treated as an ordered set.
REQ-031 A first beat without in_block_start while the counter is 0 SHALL pulse block_err, and that beat SHALL pass unscrambled.
REQ-032 Latency SHALL be exactly 1 cycle: all outputs registered, and out_valid=in_valid delayed.
REQ-033 When out_valid=0, out_data SHALL hold its previous value.

Reset
REQ-034 reset_n=0 SHALL asynchronously clear out_valid, out_block_start, out_sync_hdr, out_data, block_err and the beat counter to 0.
REQ-035 reset_n=0 SHALL set the latched type to ordered set and every LFSR to 23'h7FFFFF.
REQ-036 Deassertion of reset SHALL be synchronised externally; the first valid beat is allowed one cycle after deassertion.
REQ-037 Reset asserted mid-block SHALL discard the block, and the first post-reset beat SHALL require in_block_start.

Verification
REQ-038 Scenario: seed_load with all seeds 23'h000000, then a data block of 8'h00 -> out_data all zero, and out_valid appears 1 cycle after in_valid.
REQ-039 Scenario: seed_load with lane seeds 23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB, then a 16-symbol zero data block -> out_data matches a bit-serial reference model per lane; lanes differ.
REQ-040 Scenario: data block, SKP OS (8'hAA first), data block -> the SKP beats are unmodified, and the second data block equals the output of data, data with the SKP removed.
REQ-041 Scenario: EIEOS block (8'h00 first), then a data block -> the data block scrambles identically to the first block after seed_load.
REQ-042 Scenario: in_block_start at beat 2 of a block (DATA_BYTES=4) -> block_err=1 for one cycle; the counter restarts; the next block is correctly framed with no error.
REQ-043 Scenario: turnOff=1 during a data block, then turnOff=0 -> out_data=in_data while turnOff=1; after turnOff=0, scrambling resumes from the held LFSR state.
